// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one memory port to either the CPU or the front panel,
// with a 4-phase req/done handshake and a bounded wait for the memory completion pulse.
module mem_arbiter #(
  parameter int TIMEOUT     = 32,
  parameter bit PANEL_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_type,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_err,
  input  logic        pnl_req,
  input  logic        pnl_we,
  input  logic        pnl_type,
  input  logic [11:0] pnl_addr,
  input  logic [11:0] pnl_wdata,
  output logic        pnl_done,
  output logic        pnl_err,
  output logic [11:0] rdata,
  output logic [11:0] address,
  output logic [11:0] write_data,
  output logic        read_enable,
  output logic        write_enable,
  output logic        read_type,
  input  logic [11:0] read_data,
  input  logic        mem_finished
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [5:0] LAST_CNT = 6'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        ownerPnl_q, ownerPnl_d;
  logic        lastPnl_q, lastPnl_d;
  logic        we_q, we_d;
  logic        type_q, type_d;
  logic        err_q, err_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] rdata_q, rdata_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        pickPnl;
  logic        ownerReq;

  always_comb begin
    state_d    = state_q;
    ownerPnl_d = ownerPnl_q;
    lastPnl_d  = lastPnl_q;
    we_d       = we_q;
    type_d     = type_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    pickPnl    = pnl_req && (!cpu_req || !lastPnl_q);
    ownerReq   = ownerPnl_q ? pnl_req : cpu_req;

    case (state_q)
      IDLE: begin
        if (cpu_req || pnl_req) begin
          ownerPnl_d = pickPnl;
          we_d       = pickPnl ? pnl_we    : cpu_we;
          type_d     = pickPnl ? pnl_type  : cpu_type;
          addr_d     = pickPnl ? pnl_addr  : cpu_addr;
          wdata_d    = pickPnl ? pnl_wdata : cpu_wdata;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // A completion arriving on the last permitted cycle still counts as success.
        if (mem_finished) begin
          if (!we_q) rdata_d = read_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        lastPnl_d = ownerPnl_q;
        state_d   = RELEASE;
      end
      default: begin
        if (!ownerReq) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q    <= IDLE;
      ownerPnl_q <= 1'b0;
      lastPnl_q  <= ~PANEL_FIRST;
      we_q       <= 1'b0;
      type_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ownerPnl_q <= ownerPnl_d;
      lastPnl_q  <= lastPnl_d;
      we_q       <= we_d;
      type_q     <= type_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Command outputs decode directly from state so an asynchronous reset drops them at once.
  assign read_enable  = (state_q == ACCESS) && !we_q;
  assign write_enable = (state_q == ACCESS) && we_q;
  assign read_type    = type_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign rdata        = rdata_q;
  assign cpu_done     = (state_q == DONE) && !ownerPnl_q;
  assign pnl_done     = (state_q == DONE) && ownerPnl_q;
  assign cpu_err      = cpu_done && err_q;
  assign pnl_err      = pnl_done && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, handshake corner sequences and
// randomized traffic checked against a transaction-level round-robin model.
module tb_mem_arbiter;

  localparam int TIMEOUT     = 32;
  localparam bit PANEL_FIRST = 1'b1;

  logic        clk;
  logic        btnCpuReset;
  logic        cpu_req, cpu_we, cpu_type, cpu_done, cpu_err;
  logic [11:0] cpu_addr, cpu_wdata;
  logic        pnl_req, pnl_we, pnl_type, pnl_done, pnl_err;
  logic [11:0] pnl_addr, pnl_wdata;
  logic [11:0] rdata, address, write_data, read_data;
  logic        read_enable, write_enable, read_type, mem_finished;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .PANEL_FIRST(PANEL_FIRST)) dut (
    .clk(clk), .btnCpuReset(btnCpuReset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_type(pnl_type), .pnl_addr(pnl_addr),
    .pnl_wdata(pnl_wdata), .pnl_done(pnl_done), .pnl_err(pnl_err),
    .rdata(rdata), .address(address), .write_data(write_data),
    .read_enable(read_enable), .write_enable(write_enable), .read_type(read_type),
    .read_data(read_data), .mem_finished(mem_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pnl;
    logic        we;
    logic        typ;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] rd;
    int          finAt;
    logic [11:0] expRdata;
    logic        expErr;
    int          expEn;
  } vec_t;

  typedef struct packed {
    logic        cpuDone;
    logic        pnlDone;
    logic        err;
    logic [11:0] rdata;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic        typ;
    logic        sawRe;
    logic        sawWe;
    logic        bothEn;
    logic        addrStable;
    logic        timedOut;
    int          enCycles;
    int          doneIdx;
  } obs_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit pnl, input bit req, input bit we, input bit typ,
                               input logic [11:0] addr, input logic [11:0] wdata);
    if (pnl) begin
      pnl_req = req; pnl_we = we; pnl_type = typ; pnl_addr = addr; pnl_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_type = typ; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // Acts as the memory: answers with mem_finished on the finAt-th enabled cycle (0 = never).
  task automatic serveAccess(input int finAt, input bit scramble, output obs_t o);
    o = '0;
    o.addrStable = 1'b1;
    o.timedOut   = 1'b1;
    for (int idx = 1; idx <= 150; idx++) begin
      @(negedge clk);
      if (read_enable || write_enable) begin
        o.enCycles++;
        if (o.enCycles == 1) begin
          o.addr  = address;
          o.wdata = write_data;
          o.typ   = read_type;
          o.sawRe = read_enable;
          o.sawWe = write_enable;
          if (scramble) begin
            cpu_addr ^= 12'o0200;  pnl_addr ^= 12'o0200;
            cpu_wdata = ~cpu_wdata; pnl_wdata = ~pnl_wdata;
            cpu_we = ~cpu_we; pnl_we = ~pnl_we; cpu_type = ~cpu_type; pnl_type = ~pnl_type;
          end
        end else if (address !== o.addr || write_data !== o.wdata) begin
          o.addrStable = 1'b0;
        end
        if (read_enable && write_enable) o.bothEn = 1'b1;
        mem_finished = (o.enCycles == finAt);
      end else begin
        mem_finished = 1'b0;
      end
      if (cpu_done || pnl_done) begin
        o.cpuDone  = cpu_done;
        o.pnlDone  = pnl_done;
        o.err      = cpu_err | pnl_err;
        o.rdata    = rdata;
        o.doneIdx  = idx;
        o.timedOut = 1'b0;
        break;
      end
    end
    mem_finished = 1'b0;
  endtask

  task automatic releaseReq(input bit pnl);
    if (pnl) pnl_req = 1'b0; else cpu_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    btnCpuReset = 1'b0;
    applyStimulus(0, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0);
    mem_finished = 1'b0;
    read_data    = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstEnables", 32'({read_enable, write_enable}), 32'd0);
    checkOutput("rstDoneErr", 32'({cpu_done, cpu_err, pnl_done, pnl_err}), 32'd0);
    checkOutput("rstAddr", 32'(address), 32'd0);
    checkOutput("rstWdata", 32'(write_data), 32'd0);
    checkOutput("rstRdata", 32'(rdata), 32'd0);
    btnCpuReset = 1'b1;
  endtask

  function automatic vec_t mkVec(input bit pnl, input bit we, input bit typ,
                                 input logic [11:0] addr, input logic [11:0] wdata,
                                 input logic [11:0] rd, input int finAt,
                                 input logic [11:0] expRdata);
    vec_t v;
    v.pnl = pnl; v.we = we; v.typ = typ; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.finAt = finAt; v.expRdata = expRdata;
    v.expErr = (finAt == 0);
    v.expEn  = (finAt == 0) ? TIMEOUT : finAt;
    return v;
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs[6];
    obs_t  o;
    logic  lastPnl;
    logic  pend[2];
    logic  rqWe[2], rqTyp[2];
    logic [11:0] rqAddr[2], rqWdata[2];
    logic [11:0] modelRdata;
    logic  found, sawDone, expPnl;
    int    finAt;

    vecs[0] = mkVec(1, 1, 0, 12'o0200, 12'o7402, 12'o0000, 3,  12'o0000);
    vecs[1] = mkVec(0, 0, 1, 12'o0200, 12'o0000, 12'o1234, 1,  12'o1234);
    vecs[2] = mkVec(0, 0, 0, 12'o0100, 12'o0000, 12'o4321, 2,  12'o4321);
    vecs[3] = mkVec(0, 0, 0, 12'o0777, 12'o0000, 12'o5555, 0,  12'o4321);
    vecs[4] = mkVec(1, 0, 1, 12'o7777, 12'o0000, 12'o0001, 32, 12'o0001);
    vecs[5] = mkVec(1, 1, 0, 12'o0000, 12'o7777, 12'o3333, 5,  12'o0001);

    btnCpuReset = 1'b0;
    doReset();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].pnl, 1, vecs[i].we, vecs[i].typ, vecs[i].addr, vecs[i].wdata);
      read_data = vecs[i].rd;
      serveAccess(vecs[i].finAt, 1'b1, o);
      checkOutput($sformatf("v%0d noHang", i), 32'(o.timedOut), 32'd0);
      checkOutput($sformatf("v%0d owner", i), 32'({o.cpuDone, o.pnlDone}),
                  32'({~vecs[i].pnl, vecs[i].pnl}));
      checkOutput($sformatf("v%0d err", i), 32'(o.err), 32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d rdata", i), 32'(o.rdata), 32'(vecs[i].expRdata));
      checkOutput($sformatf("v%0d addr", i), 32'(o.addr), 32'(vecs[i].addr));
      checkOutput($sformatf("v%0d stable", i), 32'(o.addrStable), 32'd1);
      checkOutput($sformatf("v%0d enKind", i), 32'({o.sawWe, o.sawRe, o.bothEn}),
                  32'({vecs[i].we, ~vecs[i].we, 1'b0}));
      checkOutput($sformatf("v%0d enCycles", i), 32'(o.enCycles), 32'(vecs[i].expEn));
      checkOutput($sformatf("v%0d latency", i), 32'(o.doneIdx), 32'(vecs[i].expEn + 1));
      if (vecs[i].we) checkOutput($sformatf("v%0d wdata", i), 32'(o.wdata), 32'(vecs[i].wdata));
      else            checkOutput($sformatf("v%0d rtype", i), 32'(o.typ), 32'(vecs[i].typ));
      releaseReq(vecs[i].pnl);
    end

    // Stray completion pulses while idle must not produce any activity.
    mem_finished = 1'b1;
    @(negedge clk);
    mem_finished = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idleFinDone", 32'({cpu_done, pnl_done, read_enable, write_enable}), 32'd0);
    checkOutput("idleFinRdata", 32'(rdata), 32'(12'o0001));

    // Both requesters hold requests continuously: grants must alternate.
    doReset();
    applyStimulus(0, 1, 0, 0, 12'o0011, '0);
    applyStimulus(1, 1, 0, 1, 12'o0022, '0);
    read_data = 12'o0707;
    lastPnl = ~PANEL_FIRST;
    for (int g = 0; g < 4; g++) begin
      expPnl = ~lastPnl;
      serveAccess(1, 1'b0, o);
      checkOutput($sformatf("rr%0d owner", g), 32'({o.cpuDone, o.pnlDone}), 32'({~expPnl, expPnl}));
      checkOutput($sformatf("rr%0d addr", g), 32'(o.addr), expPnl ? 32'(12'o0022) : 32'(12'o0011));
      lastPnl = expPnl;
      releaseReq(expPnl);
      if (expPnl) pnl_req = 1'b1; else cpu_req = 1'b1;
    end
    cpu_req = 1'b0;
    pnl_req = 1'b0;

    // Reset in the middle of a panel write, with a CPU read waiting behind it.
    doReset();
    applyStimulus(1, 1, 1, 0, 12'o0200, 12'o7402);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = write_enable;
    end
    checkOutput("rstMidSawWe", 32'(found), 32'd1);
    @(negedge clk);
    #2;
    btnCpuReset = 1'b0;
    #1;
    checkOutput("rstMidWeDrop", 32'(write_enable), 32'd0);
    pnl_req = 1'b0;
    applyStimulus(0, 1, 0, 0, 12'o0055, '0);
    sawDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sawDone |= pnl_done | cpu_done;
    end
    checkOutput("rstMidNoDone", 32'(sawDone), 32'd0);
    btnCpuReset = 1'b1;
    read_data = 12'o6543;
    serveAccess(1, 1'b0, o);
    checkOutput("rstMidCpuOwner", 32'({o.cpuDone, o.pnlDone}), 32'(2'b10));
    checkOutput("rstMidCpuRdata", 32'(o.rdata), 32'(12'o6543));
    checkOutput("rstMidCpuAddr", 32'(o.addr), 32'(12'o0055));
    checkOutput("rstMidCpuLat", 32'(o.doneIdx), 32'd2);
    releaseReq(1'b0);

    // Random traffic against a transaction-level model: pending requests, round-robin pointer, rdata.
    doReset();
    lastPnl    = ~PANEL_FIRST;
    modelRdata = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 60; r++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k]    = 1'b1;
          rqWe[k]    = 1'($urandom);
          rqTyp[k]   = 1'($urandom);
          rqAddr[k]  = 12'($urandom);
          rqWdata[k] = 12'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1; rqWe[0] = 1'($urandom); rqTyp[0] = 1'($urandom);
        rqAddr[0] = 12'($urandom); rqWdata[0] = 12'($urandom);
      end
      applyStimulus(0, pend[0], rqWe[0], rqTyp[0], rqAddr[0], rqWdata[0]);
      applyStimulus(1, pend[1], rqWe[1], rqTyp[1], rqAddr[1], rqWdata[1]);
      read_data = 12'($urandom);
      finAt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      expPnl = (pend[0] && pend[1]) ? ~lastPnl : pend[1];
      if (!rqWe[expPnl] && finAt != 0) modelRdata = read_data;
      serveAccess(finAt, 1'b0, o);
      checkOutput($sformatf("rnd%0d noHang", r), 32'(o.timedOut), 32'd0);
      checkOutput($sformatf("rnd%0d owner", r), 32'({o.cpuDone, o.pnlDone}), 32'({~expPnl, expPnl}));
      checkOutput($sformatf("rnd%0d err", r), 32'(o.err), 32'(finAt == 0));
      checkOutput($sformatf("rnd%0d rdata", r), 32'(o.rdata), 32'(modelRdata));
      checkOutput($sformatf("rnd%0d addr", r), 32'(o.addr), 32'(rqAddr[expPnl]));
      checkOutput($sformatf("rnd%0d enKind", r), 32'({o.sawWe, o.sawRe}),
                  32'({rqWe[expPnl], ~rqWe[expPnl]}));
      if (rqWe[expPnl])
        checkOutput($sformatf("rnd%0d wdata", r), 32'(o.wdata), 32'(rqWdata[expPnl]));
      lastPnl = expPnl;
      pend[expPnl] = 1'b0;
      releaseReq(expPnl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
